// File: rtl/exec_mem_unit_pkg.sv
// Shared types and constants for the execute/memory slice of the 8-bit datapath.
package exec_mem_unit_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ACODE_ADD  = 3'b000,
    ACODE_ADDC = 3'b001,
    ACODE_SUB  = 3'b010,
    ACODE_SUBC = 3'b011,
    ACODE_AND  = 3'b100,
    ACODE_OR   = 3'b101,
    ACODE_XOR  = 3'b110,
    ACODE_MASK = 3'b111
  } acode_e;

  typedef enum logic [1:0] {
    SCODE_SHL = 2'b00,
    SCODE_SHR = 2'b01,
    SCODE_ROL = 2'b10,
    SCODE_ROR = 2'b11
  } scode_e;

  typedef enum logic [1:0] {
    FWD_ID   = 2'b00,
    FWD_EX   = 2'b01,
    FWD_WB   = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_e;

endpackage

// File: rtl/exec_mem_unit_if.sv
// Operand, ALU-control and data-memory signals of the execute/memory slice.
interface exec_mem_unit_if;
  import exec_mem_unit_pkg::*;

  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic [DATA_W-1:0] id_data_1;
  logic [DATA_W-1:0] id_data_2;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] wb_data;
  logic              is_shift;
  logic [2:0]        shamt;
  logic              alu_src;
  logic [DATA_W-1:0] imm;
  logic [2:0]        acode;
  logic [1:0]        scode;
  logic              update_z_c;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry_out;
  logic              zero;
  logic              carry;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output forward_a, forward_b, id_data_1, id_data_2, ex_result, wb_data,
           is_shift, shamt, alu_src, imm, acode, scode, update_z_c,
           mem_addr, mem_wdata, mem_write,
    input  alu_result, alu_carry_out, zero, carry, mem_rdata
  );

  modport slave (
    input  forward_a, forward_b, id_data_1, id_data_2, ex_result, wb_data,
           is_shift, shamt, alu_src, imm, acode, scode, update_z_c,
           mem_addr, mem_wdata, mem_write,
    output alu_result, alu_carry_out, zero, carry, mem_rdata
  );

endinterface

// File: rtl/exec_mem_unit_operand_forward_mux.sv
// Picks an ALU operand from the ID stage, the EX/MEM result or the MEM/WB value.
module operand_forward_mux
  import exec_mem_unit_pkg::*;
(
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_id,
  input  logic [DATA_W-1:0] i_ex,
  input  logic [DATA_W-1:0] i_wb,
  output logic [DATA_W-1:0] o_operand
);

  // The reserved encoding falls back to the ID value.
  always_comb begin
    o_operand = i_id;
    case (fwd_e'(i_sel))
      FWD_EX:  o_operand = i_ex;
      FWD_WB:  o_operand = i_wb;
      default: o_operand = i_id;
    endcase
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: forwarded operands, 8-bit ALU with registered Z/C flags,
// and an asynchronous-read data memory cleared by reset.
module exec_mem_unit
  import exec_mem_unit_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  exec_mem_unit_if.slave bus
);

  logic [DATA_W-1:0] w_b_pre;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [2:0]        w_n;
  logic [DATA_W:0]   w_alu9;
  logic              r_zero;
  logic              r_carry;
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  assign w_b_pre = bus.is_shift ? {5'b0, bus.shamt} : bus.id_data_2;

  operand_forward_mux u_fwd_a (
    .i_sel     (bus.forward_a),
    .i_id      (bus.id_data_1),
    .i_ex      (bus.ex_result),
    .i_wb      (bus.wb_data),
    .o_operand (w_op_a)
  );

  operand_forward_mux u_fwd_b (
    .i_sel     (bus.forward_b),
    .i_id      (w_b_pre),
    .i_ex      (bus.ex_result),
    .i_wb      (bus.wb_data),
    .o_operand (w_fwd_b)
  );

  assign w_op_b = bus.alu_src ? bus.imm : w_fwd_b;
  assign w_n    = w_op_b[2:0];

  // Bit 8 of w_alu9 is the carry/borrow; shifts place their last bit out there.
  always_comb begin
    w_alu9 = '0;
    if (bus.is_shift) begin
      case (scode_e'(bus.scode))
        SCODE_SHL: w_alu9 = {1'b0, w_op_a} << w_n;
        SCODE_SHR: begin
          w_alu9[7:0] = w_op_a >> w_n;
          w_alu9[8]   = (w_n != 3'd0) ? w_op_a[w_n - 3'd1] : 1'b0;
        end
        SCODE_ROL: w_alu9 = {1'b0, (w_op_a << w_n) | (w_op_a >> (4'd8 - {1'b0, w_n}))};
        SCODE_ROR: w_alu9 = {1'b0, (w_op_a >> w_n) | (w_op_a << (4'd8 - {1'b0, w_n}))};
        default:   w_alu9 = '0;
      endcase
    end else begin
      case (acode_e'(bus.acode))
        ACODE_ADD:  w_alu9 = {1'b0, w_op_a} + {1'b0, w_op_b};
        ACODE_ADDC: w_alu9 = {1'b0, w_op_a} + {1'b0, w_op_b} + {8'b0, r_carry};
        ACODE_SUB:  w_alu9 = {1'b0, w_op_a} - {1'b0, w_op_b};
        ACODE_SUBC: w_alu9 = {1'b0, w_op_a} - {1'b0, w_op_b} - {8'b0, r_carry};
        ACODE_AND:  w_alu9 = {1'b0, w_op_a & w_op_b};
        ACODE_OR:   w_alu9 = {1'b0, w_op_a | w_op_b};
        ACODE_XOR:  w_alu9 = {1'b0, w_op_a ^ w_op_b};
        ACODE_MASK: w_alu9 = {1'b0, w_op_a & ~w_op_b};
        default:    w_alu9 = '0;
      endcase
    end
  end

  assign bus.alu_result    = w_alu9[7:0];
  assign bus.alu_carry_out = w_alu9[8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (bus.update_z_c) begin
      r_zero  <= (w_alu9[7:0] == 8'd0);
      r_carry <= w_alu9[8];
    end
  end

  assign bus.zero  = r_zero;
  assign bus.carry = r_carry;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.mem_write) begin
      r_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = r_mem[bus.mem_addr];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Randomized and directed bench for exec_mem_unit against an arithmetic reference model.
module tb_exec_mem_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   m_mem [256];
  int   m_zero;
  int   m_carry;

  exec_mem_unit_if bus ();

  exec_mem_unit #(.MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input int sel, input int id, input int ex, input int wb);
    if (sel == 1) return ex;
    if (sel == 2) return wb;
    return id;
  endfunction

  task automatic ref_alu(input int a, input int b, input int shf, input int ac, input int sc,
                         input int cin, output int res, output int c);
    int n;
    int s;
    res = 0;
    c   = 0;
    if (shf != 0) begin
      n   = b % 8;
      res = a;
      for (int k = 0; k < n; k++) begin
        case (sc)
          0: begin c = (res >> 7) & 1; res = (res << 1) & 255; end
          1: begin c = res & 1;        res = res >> 1;         end
          2: res = ((res << 1) | (res >> 7)) & 255;
          default: res = ((res >> 1) | ((res & 1) << 7)) & 255;
        endcase
      end
      if (sc >= 2) c = 0;
    end else begin
      case (ac)
        0: begin s = a + b;       res = s % 256; c = (s > 255) ? 1 : 0; end
        1: begin s = a + b + cin; res = s % 256; c = (s > 255) ? 1 : 0; end
        2: begin res = (a - b + 256) % 256;       c = (a < b) ? 1 : 0; end
        3: begin res = (a - b - cin + 512) % 256; c = (a < b + cin) ? 1 : 0; end
        4: res = a & b;
        5: res = a | b;
        6: res = a ^ b;
        default: res = a & (255 - b);
      endcase
    end
  endtask

  // Checks combinational outputs, clocks once, advances the model, checks state.
  task automatic cycle();
    int a, b, res, c;
    #1;
    a = ref_fwd(bus.forward_a, bus.id_data_1, bus.ex_result, bus.wb_data);
    b = bus.is_shift ? int'(bus.shamt) : int'(bus.id_data_2);
    b = ref_fwd(bus.forward_b, b, bus.ex_result, bus.wb_data);
    if (bus.alu_src) b = bus.imm;
    ref_alu(a, b, bus.is_shift, bus.acode, bus.scode, m_carry, res, c);
    check("alu_result", bus.alu_result, res);
    check("alu_carry_out", bus.alu_carry_out, c);
    check("rdata_pre", bus.mem_rdata, m_mem[bus.mem_addr]);
    @(posedge clk);
    if (!rst) begin
      m_zero  = 0;
      m_carry = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
    end else begin
      if (bus.update_z_c) begin
        m_zero  = (res == 0) ? 1 : 0;
        m_carry = c;
      end
      if (bus.mem_write) m_mem[bus.mem_addr] = bus.mem_wdata;
    end
    #1;
    check("zero", bus.zero, m_zero);
    check("carry", bus.carry, m_carry);
    check("rdata_post", bus.mem_rdata, m_mem[bus.mem_addr]);
  endtask

  task automatic set_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ac,
                         input logic upd);
    bus.forward_a  = 2'b00;
    bus.forward_b  = 2'b00;
    bus.is_shift   = 1'b0;
    bus.alu_src    = 1'b1;
    bus.id_data_1  = a;
    bus.imm        = b;
    bus.acode      = ac;
    bus.update_z_c = upd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_zero  = 0;
    m_carry = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    rst = 1'b0;
    bus.forward_a = '0;  bus.forward_b = '0;  bus.id_data_1 = '0; bus.id_data_2 = '0;
    bus.ex_result = '0;  bus.wb_data = '0;    bus.is_shift = 1'b0; bus.shamt = '0;
    bus.alu_src = 1'b0;  bus.imm = '0;        bus.acode = '0;     bus.scode = '0;
    bus.update_z_c = 1'b0; bus.mem_addr = 8'h3C; bus.mem_wdata = '0; bus.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_zero", bus.zero, 0);
    check("reset_carry", bus.carry, 0);
    check("reset_rdata", bus.mem_rdata, 0);
    rst = 1'b1;

    // Forwarding of operand A with ADD of B=0
    set_alu(8'h11, 8'h00, 3'b000, 1'b0);
    bus.ex_result = 8'h22;
    bus.wb_data   = 8'h33;
    for (int s = 0; s < 4; s++) begin
      bus.forward_a = 2'(s);
      #1;
      check($sformatf("fwd_a_%0d", s), bus.alu_result, (s == 1) ? 8'h22 : (s == 2) ? 8'h33 : 8'h11);
      cycle();
    end

    // Carry chain
    set_alu(8'hFF, 8'h01, 3'b000, 1'b1);
    #1;
    check("add_ff_01", bus.alu_result, 8'h00);
    cycle();
    check("add_zero_flag", bus.zero, 1);
    check("add_carry_flag", bus.carry, 1);
    set_alu(8'h10, 8'h00, 3'b001, 1'b0);
    #1;
    check("addc_10_00", bus.alu_result, 8'h11);
    cycle();

    // Subtraction borrow
    set_alu(8'h05, 8'h07, 3'b010, 1'b1);
    #1;
    check("sub_05_07", bus.alu_result, 8'hFE);
    check("sub_05_07_c", bus.alu_carry_out, 1);
    cycle();
    set_alu(8'h07, 8'h05, 3'b010, 1'b1);
    #1;
    check("sub_07_05", bus.alu_result, 8'h02);
    check("sub_07_05_c", bus.alu_carry_out, 0);
    cycle();

    // Shifts of 0x81 by 1, then by 0
    set_alu(8'h81, 8'h00, 3'b000, 1'b0);
    bus.alu_src  = 1'b0;
    bus.is_shift = 1'b1;
    bus.shamt    = 3'd1;
    for (int s = 0; s < 4; s++) begin
      bus.scode = 2'(s);
      #1;
      check($sformatf("shift1_%0d", s), bus.alu_result,
            (s == 0) ? 8'h02 : (s == 1) ? 8'h40 : (s == 2) ? 8'h03 : 8'hC0);
      if (s < 2) check($sformatf("shift1_c_%0d", s), bus.alu_carry_out, 1);
      cycle();
    end
    bus.shamt = 3'd0;
    bus.scode = 2'b00;
    #1;
    check("shift0", bus.alu_result, 8'h81);
    cycle();
    bus.is_shift = 1'b0;

    // Memory write then read
    bus.mem_addr  = 8'h3C;
    bus.mem_wdata = 8'hA5;
    bus.mem_write = 1'b1;
    #1;
    check("mem_old", bus.mem_rdata, 8'h00);
    cycle();
    check("mem_new", bus.mem_rdata, 8'hA5);
    bus.mem_write = 1'b0;
    bus.mem_wdata = 8'h5A;
    cycle();
    check("mem_read_keeps", bus.mem_rdata, 8'hA5);

    // Mid-operation reset
    set_alu(8'hFF, 8'h01, 3'b000, 1'b1);
    cycle();
    check("pre_rst_zero", bus.zero, 1);
    check("pre_rst_carry", bus.carry, 1);
    rst = 1'b0;
    bus.mem_write = 1'b1;
    bus.mem_wdata = 8'h77;
    cycle();
    check("rst_zero", bus.zero, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_mem", bus.mem_rdata, 8'h00);
    rst = 1'b1;
    bus.mem_write = 1'b0;

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      rst            = ($urandom_range(0, 59) != 0);
      bus.forward_a  = 2'($urandom_range(0, 3));
      bus.forward_b  = 2'($urandom_range(0, 3));
      bus.id_data_1  = 8'($urandom);
      bus.id_data_2  = 8'($urandom);
      bus.ex_result  = 8'($urandom);
      bus.wb_data    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.is_shift   = 1'($urandom_range(0, 1));
      bus.shamt      = 3'($urandom);
      bus.alu_src    = 1'($urandom_range(0, 1));
      bus.imm        = 8'($urandom);
      bus.acode      = 3'($urandom);
      bus.scode      = 2'($urandom);
      bus.update_z_c = 1'($urandom_range(0, 1));
      bus.mem_addr   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      bus.mem_wdata  = 8'($urandom);
      bus.mem_write  = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
